reg_write_sched: RTL and testbench

REG_WRITE_SCHED -- requirements
Module: reg_write_sched

---
 rtl/reg_write_sched_pkg.sv | 22 ++
 rtl/reg_rr_arb.sv | 36 +++
 rtl/reg_write_sched.sv | 115 +++++++++++
 tb/tb_reg_write_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_write_sched_pkg.sv
// Shared types for the register-stack write scheduler: FSM encoding,
// requester identifiers and register-index constants.
package reg_write_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_id_t;

  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

endpackage

// File: rtl/reg_rr_arb.sv
// Two-way round-robin arbiter between the ALU and memory-load requesters.
// The pointer moves to the other requester when a grant completes.
module reg_rr_arb
  import reg_write_sched_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    alu_req,
  input  logic    mem_req,
  input  logic    done,
  input  req_id_t done_id,
  output logic    grant_valid,
  output req_id_t grant_id
);

  req_id_t ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_ALU;
    end else if (done) begin
      ptr_q <= (done_id == REQ_ALU) ? REQ_MEM : REQ_ALU;
    end
  end

  always_comb begin
    grant_valid = alu_req | mem_req;
    grant_id    = REQ_ALU;
    if (alu_req && mem_req) begin
      grant_id = ptr_q;
    end else if (mem_req) begin
      grant_id = REQ_MEM;
    end
  end

endmodule

// File: rtl/reg_write_sched.sv
// Schedules register-stack writes from two requesters plus a four-register
// clear sequence. Handshake: req is held high until its one-cycle ack.
module reg_write_sched
  import reg_write_sched_pkg::*;
#(
  parameter logic [7:0] CLR_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alu_req,
  input  logic [1:0] alu_sel,
  input  logic [7:0] alu_data,
  output logic       alu_ack,
  input  logic       mem_req,
  input  logic [1:0] mem_sel,
  input  logic [7:0] mem_data,
  output logic       mem_ack,
  input  logic       clr,
  output logic       LDPI,
  output logic       I9,
  output logic       I8,
  output logic [7:0] write_data,
  output logic       busy,
  output state_t     dbg_state
);

  state_t     state_q, state_d;
  req_id_t    winner_q;
  logic [1:0] sel_q;
  logic [7:0] data_q;
  logic [1:0] clr_cnt_q;
  logic       clr_pend_q;
  logic       grant_valid;
  req_id_t    grant_id;
  logic       enter_clear;
  logic       enter_write;

  reg_rr_arb u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_req     (alu_req),
    .mem_req     (mem_req),
    .done        (state_q == S_DONE),
    .done_id     (winner_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    state_d     = state_q;
    enter_clear = 1'b0;
    enter_write = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A clear beats any write request; the request simply waits.
        if (clr || clr_pend_q) begin
          enter_clear = 1'b1;
          state_d     = S_CLEAR;
        end else if (grant_valid) begin
          enter_write = 1'b1;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_CLEAR: if (clr_cnt_q == R3) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      winner_q   <= REQ_ALU;
      sel_q      <= R0;
      data_q     <= 8'h00;
      clr_cnt_q  <= R0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (enter_clear) begin
        clr_pend_q <= 1'b0;
        clr_cnt_q  <= R0;
        sel_q      <= R0;
        data_q     <= CLR_VALUE;
      end else if (enter_write) begin
        winner_q <= grant_id;
        sel_q    <= (grant_id == REQ_MEM) ? mem_sel : alu_sel;
        data_q   <= (grant_id == REQ_MEM) ? mem_data : alu_data;
      end
      // Clear requests arriving mid-write are remembered; during CLEAR they merge.
      if ((state_q == S_WRITE || state_q == S_DONE) && clr) begin
        clr_pend_q <= 1'b1;
      end
      if (state_q == S_CLEAR) begin
        if (clr_cnt_q == R3) begin
          clr_cnt_q <= R0;
        end else begin
          clr_cnt_q <= clr_cnt_q + 2'd1;
          sel_q     <= clr_cnt_q + 2'd1;
        end
      end
    end
  end

  assign LDPI       = (state_q == S_WRITE) || (state_q == S_CLEAR);
  assign alu_ack    = (state_q == S_DONE) && (winner_q == REQ_ALU);
  assign mem_ack    = (state_q == S_DONE) && (winner_q == REQ_MEM);
  assign busy       = (state_q != S_IDLE);
  assign I9         = sel_q[1];
  assign I8         = sel_q[0];
  assign write_data = data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_reg_write_sched.sv
// Randomized and directed bench for reg_write_sched: a transaction-level
// scheduling model fills an expected queue that a monitor drains on LDPI.
module tb_reg_write_sched;
  import reg_write_sched_pkg::*;

  localparam logic [7:0] CLR_V = 8'h5A;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       alu_req, mem_req, clr;
  logic [1:0] alu_sel, mem_sel;
  logic [7:0] alu_data, mem_data;
  logic       alu_ack, mem_ack, LDPI, I9, I8, busy;
  logic [7:0] write_data;
  state_t     dbg_state;

  always #5 clk = ~clk;

  reg_write_sched #(.CLR_VALUE(CLR_V)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_req    (alu_req),
    .alu_sel    (alu_sel),
    .alu_data   (alu_data),
    .alu_ack    (alu_ack),
    .mem_req    (mem_req),
    .mem_sel    (mem_sel),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .clr        (clr),
    .LDPI       (LDPI),
    .I9         (I9),
    .I8         (I8),
    .write_data (write_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] e;
  logic [7:0]  tb_stack[4];
  bit          mon_en = 1'b0;
  bit          model_ptr = 1'b0;
  bit          ack_exp = 1'b0;
  bit          ack_id = 1'b0;
  bit          cont_mode = 1'b0;
  int          cycle = 0;
  int          last_write_cyc = -1;
  int          first_ldpi_cyc = -1;
  int          issue_cyc = 0;

  function automatic logic [11:0] pack(bit c, bit id, logic [1:0] sel, logic [7:0] d);
    return {c, id, sel, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cycle++;

  // Monitor: pops one expected entry per LDPI, expects ack on the following cycle.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (ack_exp) begin
        check("ack_alu", alu_ack, ack_id == 1'b0);
        check("ack_mem", mem_ack, ack_id == 1'b1);
        ack_exp = 1'b0;
      end else if (alu_ack || mem_ack) begin
        check("spurious_ack", {alu_ack, mem_ack}, 0);
      end
      if (LDPI) begin
        tb_stack[{I9, I8}] = write_data;
        if (first_ldpi_cyc < 0) first_ldpi_cyc = cycle;
        check("busy_on_ldpi", busy, 1);
        if (exp_q.size() == 0) begin
          check("ldpi_queue_depth", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("ldpi_sel", {I9, I8}, e[9:8]);
          check("ldpi_data", write_data, e[7:0]);
          if (!e[11]) begin
            ack_exp = 1'b1;
            ack_id  = e[10];
            if (cont_mode && last_write_cyc >= 0) check("write_spacing", cycle - last_write_cyc, 3);
            last_write_cyc = cycle;
          end
        end
      end
    end
  end

  task automatic wait_quiet();
    bit ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !ack_exp) ok = 1'b1;
    end
    if (!ok) begin
      check("quiesce_timeout", ok, 1);
      exp_q.delete();
    end
  endtask

  task automatic hold_until_ack(input bit is_mem);
    bit got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (is_mem ? mem_ack : alu_ack) got = 1'b1;
    end
    if (!got) check(is_mem ? "mem_ack_timeout" : "alu_ack_timeout", got, 1);
    if (is_mem) mem_req = 1'b0;
    else alu_req = 1'b0;
  endtask

  // Issues requests (and optionally clr) together from IDLE and predicts the
  // service order: clear first, then round-robin among waiting requesters.
  task automatic run_scenario(input bit da, input bit dm, input bit dc,
                              input logic [1:0] as, input logic [7:0] ad,
                              input logic [1:0] ms, input logic [7:0] md);
    bit first;
    @(posedge clk); #1;
    if (dc) for (int i = 0; i < 4; i++) exp_q.push_back(pack(1'b1, 1'b0, i[1:0], CLR_V));
    if (da && dm) begin
      first = model_ptr;
      exp_q.push_back(first ? pack(1'b0, 1'b1, ms, md) : pack(1'b0, 1'b0, as, ad));
      exp_q.push_back(first ? pack(1'b0, 1'b0, as, ad) : pack(1'b0, 1'b1, ms, md));
      model_ptr = first;
    end else if (da) begin
      exp_q.push_back(pack(1'b0, 1'b0, as, ad));
      model_ptr = 1'b1;
    end else if (dm) begin
      exp_q.push_back(pack(1'b0, 1'b1, ms, md));
      model_ptr = 1'b0;
    end
    first_ldpi_cyc = -1;
    issue_cyc = cycle;
    alu_req = da; alu_sel = as; alu_data = ad;
    mem_req = dm; mem_sel = ms; mem_data = md;
    clr = dc;
    @(posedge clk); #1;
    clr = 1'b0;
    fork
      begin if (da) hold_until_ack(1'b0); end
      begin if (dm) hold_until_ack(1'b1); end
    join
    wait_quiet();
    check("first_ldpi_latency", first_ldpi_cyc - issue_cyc, 1);
  endtask

  task automatic clr_during_write(input logic [1:0] as, input logic [7:0] ad);
    bit found = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(pack(1'b0, 1'b0, as, ad));
    for (int i = 0; i < 4; i++) exp_q.push_back(pack(1'b1, 1'b0, i[1:0], CLR_V));
    model_ptr = 1'b1;
    alu_req = 1'b1; alu_sel = as; alu_data = ad;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (LDPI) found = 1'b1;
    end
    if (!found) check("write_ldpi_timeout", found, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    alu_req = 1'b0;
    wait_quiet();
  endtask

  task automatic continuous_alu(input int n);
    int  low;
    bit  got;
    logic [1:0] s;
    logic [7:0] d;
    cont_mode = 1'b1;
    last_write_cyc = -1;
    @(posedge clk); #1;
    s = 2'($urandom_range(0, 3)); d = 8'($urandom_range(0, 255));
    exp_q.push_back(pack(1'b0, 1'b0, s, d));
    alu_req = 1'b1; alu_sel = s; alu_data = d;
    for (int k = 0; k < n; k++) begin
      low = 0; got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (!busy) low++;
        if (alu_ack) got = 1'b1;
      end
      check("cont_ack_seen", got, 1);
      check("busy_low_between_writes", low, 1);
      model_ptr = 1'b1;
      if (k < n - 1) begin
        s = 2'($urandom_range(0, 3)); d = 8'($urandom_range(0, 255));
        exp_q.push_back(pack(1'b0, 1'b0, s, d));
        alu_sel = s; alu_data = d;
      end else begin
        alu_req = 1'b0;
      end
    end
    wait_quiet();
    cont_mode = 1'b0;
  endtask

  task automatic reset_mid_clear();
    bit found = 1'b0;
    int ldpi_cnt = 0;
    mon_en = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (LDPI && {I9, I8} == 2'd1) found = 1'b1;
    end
    check("clear_count1_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("rst_ldpi", LDPI, 0);
    check("rst_sel", {I9, I8}, 0);
    check("rst_data", write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {alu_ack, mem_ack}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (LDPI) ldpi_cnt++;
    end
    check("no_ldpi_after_reset", ldpi_cnt, 0);
    check("idle_after_reset", busy, 0);
    model_ptr = 1'b0;
    exp_q.delete();
    ack_exp = 1'b0;
    mon_en = 1'b1;
  endtask

  initial begin
    bit da, dm, dc;
    rst_n = 1'b0;
    alu_req = 1'b0; alu_sel = 2'd0; alu_data = 8'h00;
    mem_req = 1'b0; mem_sel = 2'd0; mem_data = 8'h00;
    clr = 1'b0;
    for (int i = 0; i < 4; i++) tb_stack[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ldpi", LDPI, 0);
    check("reset_sel", {I9, I8}, 0);
    check("reset_data", write_data, 0);
    check("reset_busy", busy, 0);
    check("reset_acks", {alu_ack, mem_ack}, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Both requesters together from reset: ALU first, then MEM.
    run_scenario(1'b1, 1'b1, 1'b0, 2'd1, 8'h11, 2'd3, 8'h33);
    check("stack_r1", tb_stack[1], 8'h11);
    check("stack_r3", tb_stack[3], 8'h33);

    run_scenario(1'b1, 1'b0, 1'b0, 2'd2, 8'hA5, 2'd0, 8'h00);
    check("stack_r2", tb_stack[2], 8'hA5);

    // Clear together with a memory load: clear first, MEM write afterwards.
    run_scenario(1'b0, 1'b1, 1'b1, 2'd0, 8'h00, 2'd1, 8'h77);
    check("clr_stack_r0", tb_stack[0], CLR_V);
    check("clr_stack_r1", tb_stack[1], 8'h77);
    check("clr_stack_r2", tb_stack[2], CLR_V);
    check("clr_stack_r3", tb_stack[3], CLR_V);

    clr_during_write(2'd3, 8'hC3);
    check("clr_after_write_r3", tb_stack[3], CLR_V);

    continuous_alu(6);

    reset_mid_clear();

    for (int it = 0; it < 24; it++) begin
      da = 1'($urandom_range(0, 1));
      dm = 1'($urandom_range(0, 1));
      dc = ($urandom_range(0, 3) == 0);
      if (!da && !dm && !dc) da = 1'b1;
      run_scenario(da, dm, dc,
                   2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                   2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
